// File: rtl/spram_arb.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle read latency) among N requesters.
// Define SPRAM_ARB_RSP_BUF_EN to add per-requester response holding registers with rsp_ready_i backpressure.
module spram_arb #(
    parameter int N = 2,
    parameter int A = 16,
    parameter int D = 32,
    parameter int S = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid_i,
    output logic [N-1:0]   req_ready_o,
    input  logic [N-1:0]   req_wnr_i,
    input  logic [N*A-1:0] req_addr_i,
    input  logic [N*D-1:0] req_wdata_i,
    input  logic [N*S-1:0] req_wstrb_i,
    output logic [N-1:0]   rsp_valid_o,
    output logic [N*D-1:0] rsp_rdata_o,
`ifdef SPRAM_ARB_RSP_BUF_EN
    input  logic [N-1:0]   rsp_ready_i,
`endif
    output logic           ram_en_o,
    output logic           ram_wnr_o,
    output logic [A-1:0]   ram_addr_o,
    output logic [D-1:0]   ram_wdata_o,
    output logic [S-1:0]   ram_wstrb_o,
    input  logic [D-1:0]   ram_rdata_i
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic [PW-1:0] rd_id_q, rd_id_d;
    logic [N-1:0]  blk, elig, rd_hit;
    logic [PW-1:0] win;
    logic          gnt;
    logic          gnt_out;

    always_comb begin
        rd_hit = '0;
        if (rd_inflight_q) rd_hit[rd_id_q] = 1'b1;
    end

`ifdef SPRAM_ARB_RSP_BUF_EN
    // A requester with an unconsumed or in-flight read may not start another read.
    assign blk = ((rsp_valid_o & ~rsp_ready_i) | rd_hit) & ~req_wnr_i;
`else
    assign blk = '0;
`endif

    assign elig = req_valid_i & ~blk;

    always_comb begin
        int idx;
        idx = 0;
        gnt = 1'b0;
        win = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!gnt && elig[idx]) begin
                gnt = 1'b1;
                win = PW'(idx);
            end
        end
    end

    // rst_n only masks the outputs; the flops never see it as data.
    assign gnt_out  = gnt & rst_n;
    assign ram_en_o = gnt_out;

    always_comb begin
        req_ready_o = '0;
        ram_wnr_o   = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wstrb_o = '0;
        if (gnt_out) begin
            req_ready_o[win] = 1'b1;
            ram_wnr_o        = req_wnr_i[win];
            ram_addr_o       = req_addr_i[win*A +: A];
            ram_wdata_o      = req_wdata_i[win*D +: D];
            ram_wstrb_o      = req_wstrb_i[win*S +: S];
        end
    end

    assign ptr_d         = !gnt ? ptr_q : ((win == PW'(N-1)) ? '0 : win + PW'(1));
    assign rd_inflight_d = gnt & ~req_wnr_i[win];
    assign rd_id_d       = gnt ? win : rd_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            rd_inflight_q <= 1'b0;
            rd_id_q       <= '0;
        end else begin
            ptr_q         <= ptr_d;
            rd_inflight_q <= rd_inflight_d;
            rd_id_q       <= rd_id_d;
        end
    end

`ifdef SPRAM_ARB_RSP_BUF_EN
    logic [N-1:0]   hv_q, hv_d;
    logic [N*D-1:0] hold_q, hold_d;

    always_comb begin
        hv_d   = hv_q & ~rsp_ready_i;
        hold_d = hold_q;
        for (int i = 0; i < N; i++) begin
            if (rd_hit[i]) begin
                hold_d[i*D +: D] = ram_rdata_i;
                hv_d[i]          = ~rsp_ready_i[i];
            end
        end
    end

    always_comb begin
        rsp_rdata_o = '0;
        for (int i = 0; i < N; i++)
            rsp_rdata_o[i*D +: D] = rd_hit[i] ? ram_rdata_i : hold_q[i*D +: D];
    end

    assign rsp_valid_o = hv_q | rd_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q   <= '0;
            hold_q <= '0;
        end else begin
            hv_q   <= hv_d;
            hold_q <= hold_d;
        end
    end
`else
    assign rsp_valid_o = rd_hit;
    assign rsp_rdata_o = {N{ram_rdata_i}};
`endif

endmodule
